// File: rtl/led_bank_defs.sv
// rtl/led_bank_defs.sv - shared register offsets and duty constants for the LED PWM bank
package led_bank_defs;
  localparam int ENABLE_OFS = 0;
  localparam int BLINK_OFS  = 1;
  localparam int DUTY_OFS   = 2;
  // Widest supported duty; narrower banks take the low PWM_BITS bits.
  localparam logic [7:0] DUTY_ALL_ONES = 8'hFF;
endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one LED channel: period-aligned shadow duty, compare and gating
module pwm_channel
  import led_bank_defs::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                load_i,
  input  logic                enable_i,
  input  logic                blink_i,
  input  logic                blink_phase_i,
  output logic                led_o
);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = DUTY_ALL_ONES[PWM_BITS-1:0];

  logic [PWM_BITS-1:0] shadow_q;
  logic                led_q;
  logic                pwm_on;
  logic                led_d;

  // All-ones is forced on so a full-scale duty never shows a one-cycle gap.
  assign pwm_on = (shadow_q > pwm_cnt_i) || (shadow_q == DUTY_MAX);
  assign led_d  = enable_i & pwm_on & (~blink_i | blink_phase_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= DUTY_MAX;
      led_q    <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_q <= duty_i;
      end
      led_q <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

// File: rtl/led_pwm_bank.sv
// rtl/led_pwm_bank.sv - memory-mapped bank of PWM/blink LED channels
module led_pwm_bank
  import led_bank_defs::*;
#(
  parameter int          NUM_CH     = 16,
  parameter int          PWM_BITS   = 8,
  parameter logic [14:0] BASE_ADDR  = 15'h4000,
  parameter int          BLINK_BITS = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       memOut,
  output logic [NUM_CH-1:0] led
);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = DUTY_ALL_ONES[PWM_BITS-1:0];

  logic [NUM_CH-1:0]     enable_q;
  logic [NUM_CH-1:0]     blink_q;
  logic [PWM_BITS-1:0]   duty_q [NUM_CH];
  logic [15:0]           mem_q;
  logic [15:0]           mem_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BLINK_BITS-1:0] presc_q;
  logic                  blink_phase_q;
  logic [14:0]           ofs;
  logic                  in_win;
  logic                  period_end;
  logic                  unused_outm;

  assign ofs         = addressM - BASE_ADDR;
  assign in_win      = (addressM >= BASE_ADDR) && (ofs < 15'(DUTY_OFS + NUM_CH));
  assign period_end  = (pwm_cnt_q == DUTY_MAX);
  assign unused_outm = ^outM;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      blink_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= DUTY_MAX;
      end
    end else if (writeM && in_win) begin
      if (ofs == 15'(ENABLE_OFS)) enable_q <= outM[NUM_CH-1:0];
      if (ofs == 15'(BLINK_OFS))  blink_q  <= outM[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (ofs == 15'(DUTY_OFS + i)) duty_q[i] <= outM[PWM_BITS-1:0];
      end
    end
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    mem_d = '0;
    if (in_win) begin
      if (ofs == 15'(ENABLE_OFS)) mem_d[NUM_CH-1:0] = enable_q;
      if (ofs == 15'(BLINK_OFS))  mem_d[NUM_CH-1:0] = blink_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ofs == 15'(DUTY_OFS + i)) mem_d[PWM_BITS-1:0] = duty_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q         <= '0;
      pwm_cnt_q     <= '0;
      presc_q       <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      mem_q     <= mem_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      presc_q   <= presc_q + 1'b1;
      if (presc_q == '1) blink_phase_q <= ~blink_phase_q;
    end
  end

  assign memOut = mem_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .duty_i       (duty_q[g]),
      .pwm_cnt_i    (pwm_cnt_q),
      .load_i       (period_end),
      .enable_i     (enable_q[g]),
      .blink_i      (blink_q[g]),
      .blink_phase_i(blink_phase_q),
      .led_o        (led[g])
    );
  end
endmodule

// File: tb/tb_led_pwm_bank.sv
// tb/tb_led_pwm_bank.sv - directed self-checking bench for led_pwm_bank
module tb_led_pwm_bank;
  localparam int          NUM_CH = 16;
  localparam logic [14:0] BASE   = 15'h4000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [14:0]       addressM = '0;
  logic [15:0]       outM = '0;
  logic              writeM = 1'b0;
  logic [15:0]       memOut;
  logic [NUM_CH-1:0] led;
  logic [7:0]        mcnt;
  int                checks = 0;
  int                failures = 0;

  led_pwm_bank #(.NUM_CH(NUM_CH), .PWM_BITS(8), .BASE_ADDR(BASE), .BLINK_BITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addressM(addressM),
    .outM    (outM),
    .writeM  (writeM),
    .memOut  (memOut),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Expected period position: zero while in reset, then one step per cycle.
  always @(posedge clk) begin
    if (reset) mcnt <= 8'd0;
    else       mcnt <= mcnt + 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1'b1;
    @(negedge clk);
    writeM = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] d);
    addressM = a; writeM = 1'b0;
    @(negedge clk);
    d = memOut;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (mcnt == v) hit = 1'b1;
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL wait_cnt target=%0d not reached", v);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL rst_led got=%h exp=0000", led); end
    checks++; if (memOut !== 16'h0000) begin failures++; $display("FAIL rst_mem got=%h exp=0000", memOut); end
    reset = 1'b0;
    rd(BASE, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_enable got=%h exp=0000", d); end
    rd(BASE + 15'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_blink got=%h exp=0000", d); end
    rd(BASE + 15'd7, d);
    checks++; if (d !== 16'h00FF) begin failures++; $display("FAIL rst_duty5 got=%h exp=00ff", d); end
  endtask

  task automatic test_legacy;
    logic [15:0] d;
    int bad;
    wr(BASE, 16'h000F);
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL legacy_latency got=%h exp=0000", led); end
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (led !== 16'h000F) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL legacy_static bad_cycles=%0d exp=0", bad); end
    rd(BASE, d);
    checks++; if (d !== 16'h000F) begin failures++; $display("FAIL legacy_read got=%h exp=000f", d); end
  endtask

  task automatic test_duty;
    int lit, bad;
    wait_cnt(8'd10);
    wr(BASE + 15'd2, 16'd64);
    wr(BASE, 16'h0001);
    @(negedge clk);
    checks++; if (led !== 16'h0001) begin failures++; $display("FAIL duty_before_boundary got=%h exp=0001", led); end
    wait_cnt(8'd1);
    lit = 0; bad = 0;
    for (int j = 0; j < 256; j++) begin
      if (led[0]) lit++;
      if (led[0] !== (j < 64)) bad++;
      @(negedge clk);
    end
    checks++; if (lit != 64) begin failures++; $display("FAIL duty_lit_count got=%0d exp=64", lit); end
    checks++; if (bad != 0) begin failures++; $display("FAIL duty_pattern bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_boundary;
    int lit;
    wr(BASE + 15'd3, 16'd0);
    wr(BASE, 16'h0002);
    wait_cnt(8'd1);
    lit = 0;
    for (int j = 0; j < 256; j++) begin
      if (led[1]) lit++;
      @(negedge clk);
    end
    checks++; if (lit != 0) begin failures++; $display("FAIL duty0_never_lit got=%0d exp=0", lit); end
    wait_cnt(8'd255);
    wr(BASE + 15'd3, 16'h00FF);
    lit = 0;
    for (int j = 0; j < 256; j++) begin
      if (led[1]) lit++;
      @(negedge clk);
    end
    checks++; if (lit != 0) begin failures++; $display("FAIL boundary_write_deferred got=%0d exp=0", lit); end
    @(negedge clk);
    lit = 0;
    for (int j = 0; j < 256; j++) begin
      if (led[1]) lit++;
      @(negedge clk);
    end
    checks++; if (lit != 256) begin failures++; $display("FAIL duty255_always_lit got=%0d exp=256", lit); end
  endtask

  task automatic test_blink;
    logic [15:0] d;
    logic prev;
    int trans, badpos;
    wr(BASE + 15'd2, 16'h00FF);
    wr(BASE + 15'd1, 16'h0001);
    wr(BASE, 16'h0001);
    wait_cnt(8'd1);
    prev = led[0]; trans = 0; badpos = 0;
    @(negedge clk);
    for (int j = 1; j < 80; j++) begin
      if (led[0] !== prev) begin
        trans++;
        if (mcnt[3:0] != 4'd1) badpos++;
      end
      prev = led[0];
      @(negedge clk);
    end
    checks++; if (trans != 4) begin failures++; $display("FAIL blink_toggles got=%0d exp=4", trans); end
    checks++; if (badpos != 0) begin failures++; $display("FAIL blink_spacing misplaced=%0d exp=0", badpos); end
    rd(BASE + 15'd1, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL blink_read got=%h exp=0001", d); end
  endtask

  task automatic test_address;
    logic [15:0] d;
    wr(BASE + 15'd18, 16'hFFFF);
    wr(15'h3FFF, 16'hFFFF);
    rd(BASE + 15'd18, d);  chk("unmapped_high_read", d, 16'h0000);
    rd(15'h3FFF, d);       chk("unmapped_low_read", d, 16'h0000);
    rd(BASE, d);           chk("enable_untouched", d, 16'h0001);
    rd(BASE + 15'd1, d);   chk("blink_untouched", d, 16'h0001);
    rd(BASE + 15'd17, d);  chk("duty15_untouched", d, 16'h00FF);
    wr(BASE + 15'd4, 16'hFFFF);
    rd(BASE + 15'd4, d);   chk("duty_zero_extend", d, 16'h00FF);
    addressM = BASE; outM = 16'hA5A5; writeM = 1'b1;
    @(negedge clk);
    writeM = 1'b0;
    chk("rw_same_cycle_old", memOut, 16'h0001);
    @(negedge clk);
    chk("rw_same_cycle_new", memOut, 16'hA5A5);
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    wr(BASE + 15'd1, 16'h0000);
    wr(BASE, 16'hFFFF);
    @(negedge clk);
    chk("all_lit_before_reset", led, 16'hFFFF);
    addressM = BASE + 15'd2; outM = 16'h0005; writeM = 1'b1; reset = 1'b1;
    @(negedge clk);
    writeM = 1'b0;
    chk("reset_led", led, 16'h0000);
    chk("reset_mem", memOut, 16'h0000);
    reset = 1'b0;
    rd(BASE + 15'd2, d);   chk("reset_write_discarded", d, 16'h00FF);
    rd(BASE, d);           chk("reset_enable_cleared", d, 16'h0000);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_legacy();
    test_duty();
    test_boundary();
    test_blink();
    test_address();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, meaning number of LED channels (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning duty/counter width (2..8).
REQ-003 SHALL have parameter BASE_ADDR, default 15'h4000, meaning base of the memory-mapped window.
REQ-004 SHALL have parameter BLINK_BITS, default 24, meaning blink prescaler width.
REQ-005 SHALL have port clk, input, 1, meaning the system clock; one clock only.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port addressM, input, 15, meaning the CPU data address.
REQ-008 SHALL have port outM, input, 16, meaning the CPU write data.
REQ-009 SHALL have port writeM, input, 1, meaning the CPU write strobe.
REQ-010 SHALL have port memOut, output, 16, meaning read data for the window.
REQ-011 SHALL have port led, output, NUM_CH, meaning the LED drive, 1 = lit.

Function
REQ-012 SHALL use this register map: BASE+0 ENABLE[NUM_CH-1:0]; BASE+1 BLINK[NUM_CH-1:0]; BASE+2+i DUTY[i][PWM_BITS-1:0] for i < NUM_CH.
REQ-013 SHALL perform a write when writeM=1 and addressM is mapped, updating the register on that clk edge.
REQ-014 SHALL ignore writes to unmapped addresses, including BASE+2+i with i >= NUM_CH.
REQ-015 SHALL zero-extend register bits above NUM_CH/PWM_BITS on read and ignore them on write.
REQ-016 SHALL register memOut, valid one cycle after addressM is presented.
REQ-017 SHALL return 0 on memOut for unmapped addresses.
REQ-018 SHALL return the pre-write value on memOut when a read and a write hit the same address in the same cycle.
REQ-019 SHALL run a free-running counter pwm_cnt of PWM_BITS bits, incrementing every cycle and wrapping from max to 0.
REQ-020 SHALL hold a per-channel shadow duty, loaded from DUTY[i] on the cycle pwm_cnt == max, so duty changes take effect only at a period boundary.
REQ-021 SHALL land a DUTY write made in that boundary cycle in the following period.
REQ-022 SHALL define the PWM output as pwm_on[i] = (shadow[i] > pwm_cnt) OR (shadow[i] == all-ones); duty 0 never lights, all-ones is constantly lit.
REQ-023 SHALL run a BLINK_BITS prescaler; blink_phase toggles when the prescaler wraps.
REQ-024 SHALL drive led[i] as a register = ENABLE[i] AND pwm_on[i] AND (NOT BLINK[i] OR blink_phase).
REQ-025 SHALL show an ENABLE/BLINK write sampled at edge k on led at edge k+1.
REQ-026 SHALL make the legacy single-write use (ENABLE only) behave as static LEDs, because DUTY resets to all-ones.

Reset
REQ-027 SHALL clear on reset: ENABLE, BLINK, pwm_cnt, prescaler, memOut and led to 0.
REQ-028 SHALL set on reset: DUTY and shadow to all-ones, and blink_phase to 1.
REQ-029 SHALL, when reset is asserted mid-period or mid-write, take reset values on that edge and discard the write.
REQ-030 SHALL resume counting at 0 in the first cycle after reset deasserts.

Structure
REQ-031 SHALL place register offsets (ENABLE_OFS=0, BLINK_OFS=1, DUTY_OFS=2) and the all-ones duty constant in shared header led_bank_defs.
REQ-032 SHALL implement each channel's shadow register, compare and gating in one sub-module pwm_channel, instantiated NUM_CH times by generate.
REQ-033 SHALL keep pwm_cnt, the prescaler and the register file in the top level.

Verification
REQ-034 Legacy test: reset; write 0x000F to 0x4000 -> led == 0x000F continuously from the following cycle; read 0x4000 -> memOut 0x000F.
REQ-035 Duty test: DUTY[0]=64, ENABLE=1, PWM_BITS=8 -> exactly 64 lit cycles per 256-cycle period, starting at the first period boundary after the write.
REQ-036 Boundary test: DUTY[1]=0 -> led[1] never lit; DUTY[1]=255 -> lit every cycle; a write in the pwm_cnt==255 cycle applies one period later.
REQ-037 Blink test: BLINK_BITS=4, BLINK=1, ENABLE=1 -> led[0] toggles every 16 cycles; read 0x4001 -> memOut 0x0001.
REQ-038 Address test: write 0xFFFF to BASE+2+NUM_CH and to 0x3FFF -> no register change, reads return 0; read and write to BASE+0 in the same cycle -> memOut returns the old value.
REQ-039 Reset test: assert reset mid-period with ENABLE=0xFFFF -> led == 0 on the next edge; DUTY reads 0x00FF after release.
